// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Receive-side Morse decoder. A keyed on/off line is synchronised, mark and
// space lengths are measured, and each mark is classified as a dot or a dash.
// Elements are grouped into characters and decoded to ASCII (A-Z, 0-9, '?').
// Decoded characters go into a 32-byte register file readable over an
// Avalon-style port. Byte 0 is status, bytes 1..31 hold characters.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   address      register address (0 = status, 1..31 = characters)
//   read_data    register[address], combinational
//   write_enable write strobe; any write to address 0 clears the decoder
//   write_data   write data (content is irrelevant for the soft clear)
//   key_in       asynchronous keyed input, 1 = mark
//   busy         high while in MARK, SPACE, STORE or GAP
//   done_irq     message-complete level, mirrors status bit0
//
// Status byte: bit0 done, bit1 overflow, bits 4:2 state code
//   (IDLE=0, MARK=1, SPACE=2, STORE=3, GAP=4, DONE=5), other bits 0.
// The measurement counter restarts at 1 on every key_s edge, so during a
// level it holds the number of cycles that level has lasted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module morse_decoder #(
    parameter int unsigned DOT_CYCLES    = 12500000,
    parameter int unsigned GLITCH_CYCLES = 3125000,
    parameter int unsigned END_UNITS     = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] address,
    output logic [7:0] read_data,
    input  logic       write_enable,
    input  logic [7:0] write_data,
    input  logic       key_in,
    output logic       busy,
    output logic       done_irq
);

    localparam logic [31:0] GLITCH_T = 32'(GLITCH_CYCLES);
    localparam logic [31:0] DASH_T   = 32'(2 * DOT_CYCLES);
    localparam logic [31:0] LETTER_T = 32'(2 * DOT_CYCLES);
    localparam logic [31:0] END_T    = 32'(END_UNITS * DOT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MARK  = 3'd1,
        ST_SPACE = 3'd2,
        ST_STORE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // International Morse lookup; pat holds elements with the first one in
    // the MSB of the used bits, dash = 1. Length 0 or 6 yields '?'.
    function automatic logic [7:0] decode_char(input logic [2:0] len, input logic [4:0] pat);
        logic [7:0] ch;
        ch = 8'h3F;
        case (len)
            3'd1: ch = pat[0] ? 8'h54 : 8'h45;
            3'd2: begin
                case (pat[1:0])
                    2'b00:   ch = 8'h49;
                    2'b01:   ch = 8'h41;
                    2'b10:   ch = 8'h4E;
                    2'b11:   ch = 8'h4D;
                    default: ch = 8'h3F;
                endcase
            end
            3'd3: begin
                case (pat[2:0])
                    3'b000:  ch = 8'h53;
                    3'b001:  ch = 8'h55;
                    3'b010:  ch = 8'h52;
                    3'b011:  ch = 8'h57;
                    3'b100:  ch = 8'h44;
                    3'b101:  ch = 8'h4B;
                    3'b110:  ch = 8'h47;
                    3'b111:  ch = 8'h4F;
                    default: ch = 8'h3F;
                endcase
            end
            3'd4: begin
                case (pat[3:0])
                    4'b0000: ch = 8'h48;
                    4'b0001: ch = 8'h56;
                    4'b0010: ch = 8'h46;
                    4'b0100: ch = 8'h4C;
                    4'b0110: ch = 8'h50;
                    4'b0111: ch = 8'h4A;
                    4'b1000: ch = 8'h42;
                    4'b1001: ch = 8'h58;
                    4'b1010: ch = 8'h43;
                    4'b1011: ch = 8'h59;
                    4'b1100: ch = 8'h5A;
                    4'b1101: ch = 8'h51;
                    default: ch = 8'h3F;
                endcase
            end
            3'd5: begin
                case (pat)
                    5'b01111: ch = 8'h31;
                    5'b00111: ch = 8'h32;
                    5'b00011: ch = 8'h33;
                    5'b00001: ch = 8'h34;
                    5'b00000: ch = 8'h35;
                    5'b10000: ch = 8'h36;
                    5'b11000: ch = 8'h37;
                    5'b11100: ch = 8'h38;
                    5'b11110: ch = 8'h39;
                    5'b11111: ch = 8'h30;
                    default:  ch = 8'h3F;
                endcase
            end
            default: ch = 8'h3F;
        endcase
        return ch;
    endfunction

    logic        sync1_q, key_s_q, key_prev_q;
    logic [31:0] cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [7:0]  mem_q [0:31];
    logic [7:0]  mem_d [0:31];
    logic [5:0]  index_q, index_d;
    logic [4:0]  pattern_q, pattern_d;
    logic [2:0]  elem_len_q, elem_len_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        rise_s, fall_s, srst_s;
    logic        unused_wdata_s;

    assign rise_s         = key_s_q & ~key_prev_q;
    assign fall_s         = ~key_s_q & key_prev_q;
    assign srst_s         = write_enable && (address == 5'd0);
    assign unused_wdata_s = ^write_data;

    // Next-state logic: counter, FSM, character buffer and status flags.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        index_d    = index_q;
        pattern_d  = pattern_q;
        elem_len_d = elem_len_q;
        done_d     = done_q;
        ovf_d      = ovf_q;

        if (rise_s || fall_s) begin
            cnt_d = 32'd1;
        end else if (cnt_q == 32'hFFFF_FFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d    = ST_MARK;
                    pattern_d  = 5'd0;
                    elem_len_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (!fall_s) begin
                    state_d = ST_MARK;
                end else if (cnt_q < GLITCH_T) begin
                    // Too short to be an element; keep the character going.
                    state_d = (elem_len_q != 3'd0) ? ST_SPACE : ST_IDLE;
                end else begin
                    pattern_d  = {pattern_q[3:0], (cnt_q >= DASH_T)};
                    elem_len_d = (elem_len_q == 3'd6) ? 3'd6 : elem_len_q + 3'd1;
                    state_d    = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (rise_s) begin
                    state_d = ST_MARK;
                end else if (cnt_q >= LETTER_T) begin
                    state_d = ST_STORE;
                end else begin
                    state_d = ST_SPACE;
                end
            end
            ST_STORE: begin
                if (index_q <= 6'd31) begin
                    mem_d[index_q[4:0]] = decode_char(elem_len_q, pattern_q);
                    index_d             = index_q + 6'd1;
                end else begin
                    ovf_d = 1'b1;
                end
                pattern_d  = 5'd0;
                elem_len_d = 3'd0;
                state_d    = ST_GAP;
            end
            ST_GAP: begin
                if (rise_s) begin
                    state_d = ST_MARK;
                end else if (cnt_q >= END_T) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // Soft clear wins over everything above, including a STORE.
        if (srst_s) begin
            for (int i = 0; i < 32; i++) begin
                mem_d[i] = 8'd0;
            end
            index_d    = 6'd1;
            state_d    = ST_IDLE;
            pattern_d  = 5'd0;
            elem_len_d = 3'd0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            index_d = index_d;
        end

        busy_d = (state_d == ST_MARK) || (state_d == ST_SPACE) ||
                 (state_d == ST_STORE) || (state_d == ST_GAP);
    end

    // State, buffer and synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            key_s_q    <= 1'b0;
            key_prev_q <= 1'b0;
            cnt_q      <= 32'd0;
            state_q    <= ST_IDLE;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'd0;
            end
            index_q    <= 6'd1;
            pattern_q  <= 5'd0;
            elem_len_q <= 3'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= key_in;
            key_s_q    <= sync1_q;
            key_prev_q <= key_s_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            mem_q      <= mem_d;
            index_q    <= index_d;
            pattern_q  <= pattern_d;
            elem_len_q <= elem_len_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Register read mux; address 0 assembles the status byte.
    always_comb begin
        if (address == 5'd0) begin
            read_data = {3'b000, state_q, ovf_q, done_q};
        end else begin
            read_data = mem_q[address];
        end
    end

    assign busy     = busy_q;
    assign done_irq = done_q;

endmodule

// File: tb/tb_morse_decoder.sv
`timescale 1ns/1ps
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] address;
    logic [7:0] read_data;
    logic       write_enable;
    logic [7:0] write_data;
    logic       key_in;
    logic       busy;
    logic       done_irq;

    morse_decoder #(.DOT_CYCLES(10), .GLITCH_CYCLES(3), .END_UNITS(7)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .read_data(read_data),
        .write_enable(write_enable), .write_data(write_data), .key_in(key_in),
        .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: message-level view of the register file.
    logic [7:0] exp_mem [0:31];
    int         exp_idx;
    logic       exp_ovf, exp_done, exp_busy;
    logic       chk_en = 1'b0;

    string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    string morse_tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
        "-", "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
        "...--", "....-", ".....", "-....", "--...", "---..", "----."};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    // Code string uses '.', '-' and 'g' (a glitch mark, not an element).
    function automatic logic [7:0] lookup(input string code);
        string s;
        s = "";
        for (int i = 0; i < code.len(); i++)
            if (code[i] != "g") s = {s, code.substr(i, i)};
        if (s.len() >= 6) return 8'h3F;
        for (int k = 0; k < 36; k++)
            if (s == morse_tbl[k]) return alpha[k];
        return 8'h3F;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
        exp_idx  = 1;
        exp_ovf  = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_char(input string code);
        if (exp_idx <= 31) begin
            exp_mem[exp_idx] = lookup(code);
            exp_idx++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    // Per-cycle compare of the status outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("busy", {7'd0, busy}, {7'd0, exp_busy});
            check("done_irq", {7'd0, done_irq}, {7'd0, exp_done});
        end
    end

    // All stimulus tasks start and end on a falling clock edge.
    task automatic hold(input logic level, input int n);
        key_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic hps_write(input logic [4:0] a, input logic [7:0] d);
        address = a; write_data = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic send_char(input string code);
        int len;
        for (int i = 0; i < code.len(); i++) begin
            len = (code[i] == "-") ? 30 : (code[i] == "g") ? 2 : 10;
            hold(1'b1, len);
            if (i < code.len() - 1) hold(1'b0, 10);
        end
        model_char(code);
    endtask

    task automatic check_regs(input string name, input logic [2:0] st);
        for (int i = 0; i < 32; i++) begin
            address = 5'(i);
            #1;
            if (i == 0) check({name, "_status"}, read_data, {3'b000, st, exp_ovf, exp_done});
            else check($sformatf("%s_byte%0d", name, i), read_data, exp_mem[i]);
        end
        @(negedge clk);
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(name, read_data, exp);
        @(negedge clk);
    endtask

    task automatic do_clear();
        chk_en = 1'b0;
        hps_write(5'd0, 8'h00);
        model_clear();
        exp_busy = 1'b0;
        chk_en   = 1'b1;
    endtask

    // Send a message: chars separated by 30-cycle gaps, then wait for DONE.
    task automatic send_msg(input string codes [$]);
        chk_en = 1'b0;
        foreach (codes[i]) begin
            send_char(codes[i]);
            exp_busy = 1'b1;
            chk_en   = 1'b1;
            if (i < codes.size() - 1) hold(1'b0, 30);
        end
        hold(1'b0, 60);
        chk_en = 1'b0;
        hold(1'b0, 20);
        exp_busy = 1'b0;
        exp_done = 1'b1;
        chk_en   = 1'b1;
    endtask

    initial begin
        string q [$];
        rst_n = 1'b0; key_in = 1'b0; address = 5'd0;
        write_enable = 1'b0; write_data = 8'h00;
        model_clear();
        exp_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check_regs("reset", 3'd0);

        // ".-" -> 'A'
        q = '{".-"};
        send_msg(q);
        check_regs("msg_a", 3'd5);
        rd_check("a_literal", 5'd1, 8'h41);
        rd_check("a_status_literal", 5'd0, 8'h15);
        hps_write(5'd1, 8'hFF);
        rd_check("ignored_write", 5'd1, 8'h41);

        // Soft clear from DONE
        do_clear();
        check_regs("clear", 3'd0);

        // SOS
        q = '{"...", "---", "..."};
        send_msg(q);
        check_regs("sos", 3'd5);
        rd_check("sos_s1", 5'd1, 8'h53);
        rd_check("sos_o", 5'd2, 8'h4F);
        rd_check("sos_s2", 5'd3, 8'h53);

        // Glitch inside a character
        do_clear();
        q = '{".g."};
        send_msg(q);
        check_regs("glitch", 3'd5);
        rd_check("glitch_i", 5'd1, 8'h49);

        // Six elements, then two digits
        do_clear();
        q = '{"......", ".....", "-----"};
        send_msg(q);
        check_regs("digits", 3'd5);
        rd_check("six_q", 5'd1, 8'h3F);
        rd_check("digit5", 5'd2, 8'h35);
        rd_check("digit0", 5'd3, 8'h30);

        // 32 'E' characters overflow the buffer
        do_clear();
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(".");
        send_msg(q);
        check_regs("overflow", 3'd5);
        rd_check("ovf_status", 5'd0, 8'h17);
        rd_check("ovf_last", 5'd31, 8'h45);

        // Soft clear in the middle of a mark
        do_clear();
        chk_en = 1'b0;
        hold(1'b1, 8);
        hps_write(5'd0, 8'h00);
        model_clear();
        check("busy_after_clear", {7'd0, busy}, 8'h00);
        exp_busy = 1'b0;
        chk_en   = 1'b1;
        check_regs("midmark_clear", 3'd0);
        hold(1'b1, 5);
        hold(1'b0, 10);
        q = '{".-"};
        send_msg(q);
        check_regs("after_clear", 3'd5);
        rd_check("after_clear_a", 5'd1, 8'h41);

        // Async reset in the middle of a space
        do_clear();
        chk_en = 1'b0;
        send_char(".-");
        hold(1'b0, 30);
        send_char(".");
        hold(1'b0, 5);
        check("busy_pre_reset", {7'd0, busy}, 8'h01);
        address = 5'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_busy", {7'd0, busy}, 8'h00);
        check("reset_done", {7'd0, done_irq}, 8'h00);
        check("reset_byte1", read_data, 8'h00);
        address = 5'd0;
        #1;
        check("reset_status", read_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
